// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Subtraction is a + ~b + 1, with the +1 injected through the initial carry.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bit_s, bit_c;

  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        part_d  = {bit_s, part_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = bit_c;
        if (cnt_q == LastBit) begin
          // Counter is held on the last bit so it never wraps.
          sum_d   = {bit_s, part_q[WIDTH-1:1]};
          cout_d  = bit_c;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and protocol
// vectors, and a 4-bit instance swept over every (a, b, sub) combination.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] hold8 = '0;
  logic [4:0] hold4 = '0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on each done pulse; otherwise the result must hold its last value.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!rst_n) begin
      q8.delete();
      hold8 = '0;
    end else begin
      check("busy8_and_done8", {31'd0, busy8 & done8}, 32'd0);
      if (done8) begin
        if (q8.size() == 0) begin
          check("done8_without_request", q8.size(), 32'd1);
        end else begin
          e = q8.pop_front();
          check("result8", {23'd0, cout8, sum8}, {23'd0, e});
          hold8 = e;
        end
      end else begin
        check("hold8", {23'd0, cout8, sum8}, {23'd0, hold8});
      end
    end
  end

  initial forever begin
    logic [4:0] e;
    @(negedge clk);
    if (!rst_n) begin
      q4.delete();
      hold4 = '0;
    end else begin
      check("busy4_and_done4", {31'd0, busy4 & done4}, 32'd0);
      if (done4) begin
        if (q4.size() == 0) begin
          check("done4_without_request", q4.size(), 32'd1);
        end else begin
          e = q4.pop_front();
          check("result4", {27'd0, cout4, sum4}, {27'd0, e});
          hold4 = e;
        end
      end else begin
        check("hold4", {27'd0, cout4, sum4}, {27'd0, hold4});
      end
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                     input logic [8:0] exp);
    int nb;
    @(posedge clk); #1;
    a8 = av; b8 = bv; sub8 = sv; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~av; b8 = ~bv; sub8 = ~sv;
    nb = 0;
    while (busy8 && nb < 40) begin
      nb++;
      @(posedge clk); #1;
    end
    check("busy8_cycles", nb, 32'd8);
    check("done8_after_busy", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    check("done8_one_cycle", {31'd0, done8}, 32'd0);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                     input logic [4:0] exp);
    int nb;
    @(posedge clk); #1;
    a4 = av; b4 = bv; sub4 = sv; start4 = 1'b1;
    q4.push_back(exp);
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~av; b4 = ~bv; sub4 = ~sv;
    nb = 0;
    while (busy4 && nb < 20) begin
      nb++;
      @(posedge clk); #1;
    end
    check("busy4_cycles", nb, 32'd4);
    @(posedge clk); #1;
  endtask

  task automatic wait_done8(output int t);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done8 && n < 40);
    if (!done8) check("done8_timeout", {31'd0, done8}, 32'd1);
    t = cyc;
  endtask

  logic [7:0] pa[4], pb[4];
  logic       ps[4];
  logic [8:0] pe[4];

  initial begin
    int t, last, nd;
    pa[0] = 8'h11; pb[0] = 8'h22; ps[0] = 1'b0; pe[0] = 9'h033;
    pa[1] = 8'hF0; pb[1] = 8'h0F; ps[1] = 1'b0; pe[1] = 9'h0FF;
    pa[2] = 8'h80; pb[2] = 8'h01; ps[2] = 1'b1; pe[2] = 9'h17F;
    pa[3] = 8'h05; pb[3] = 8'h06; ps[3] = 1'b1; pe[3] = 9'h0FF;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_result8", {23'd0, cout8, sum8}, 32'd0);
    check("rst_result4", {27'd0, cout4, sum4}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed 8-bit vectors; the subtract that borrows runs last so the
    // reset test below starts from a non-zero held result.
    op8(8'h5A, 8'h3C, 1'b0, 9'h096);
    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    op8(8'hFF, 8'hFF, 1'b0, 9'h1FE);
    op8(8'h10, 8'h01, 1'b1, 9'h10F);
    op8(8'h00, 8'h00, 1'b1, 9'h100);
    op8(8'h01, 8'h02, 1'b1, 9'h0FF);

    // start held high, operands scrambled after each acceptance.
    @(posedge clk); #1;
    a8 = pa[0]; b8 = pb[0]; sub8 = ps[0]; start8 = 1'b1;
    q8.push_back(pe[0]);
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55; sub8 = ~ps[0];
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done8(t);
      if (i > 0) check("done8_period", t - last, 32'd10);
      last = t;
      if (i < 3) begin
        a8 = pa[i+1]; b8 = pb[i+1]; sub8 = ps[i+1];
        q8.push_back(pe[i+1]);
        @(posedge clk);
        @(posedge clk); #1;
        a8 = 8'hC3; b8 = 8'h3C; sub8 = ~ps[i+1];
      end else begin
        start8 = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset on the 4th RUN cycle aborts the operation.
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy8", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    check("abort_done8", {31'd0, done8}, 32'd0);
    check("abort_result8", {23'd0, cout8, sum8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("no_done8_after_abort", nd, 32'd0);
    op8(8'h01, 8'h01, 1'b0, 9'h002);

    // Exhaustive 4-bit sweep.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          logic [3:0] av, bv, bo;
          logic       sv;
          logic [4:0] e;
          av = x[3:0];
          bv = y[3:0];
          sv = s[0];
          bo = sv ? ~bv : bv;
          e  = {1'b0, av} + {1'b0, bo} + {4'd0, sv};
          op4(av, bv, sv, e);
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", q8.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
